branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Execute-side counterpart of the fetch-stage branch predictor. Takes resolved branch/jump outcomes from execute and compares them with the prediction that travelled down the pipe.
- On a mispredict it issues a one-shot redirect PC and holds flush until the front end acknowledges.
- Owns the 2-bit saturating direction counters. Queues BTB updates and drains them to the predictor's BTB write port through a ready/valid handshake.

Parameters:
- ADDR_W, `ADDRESS_SIZE (64): PC/target width.
- INSTR_W, `INSTRUCTION_SIZE (32): instruction width.
- BTB_ENTRIES, `BTB_SIZE (16): BTB/counter-table entries; power of 2; IDX_W = log2(BTB_ENTRIES).
- UPD_DEPTH, 4: update FIFO depth; power of 2, at least 2.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- res_valid  in  1  resolved control-flow instruction present.
- res_ready  out  1  block accepts a resolve this cycle.
- res_pc  in  ADDR_W  PC of the resolved instruction.
- res_instruction  in  INSTR_W  instruction word (opcode in [6:0]).
- res_taken  in  1  actual direction.
- res_target  in  ADDR_W  actual taken target.
- pred_taken  in  1  direction the front end predicted.
- pred_target  in  ADDR_W  target the front end used when predicted taken.
- redirect_valid  out  1  one-cycle pulse; front end loads redirect_pc.
- redirect_pc  out  ADDR_W  corrected fetch PC.
- flush  out  1  squash younger instructions; held until flush_ack.
- flush_ack  in  1  front end/pipeline drained.
- btb_wr_valid  out  1  BTB write request.
- btb_wr_ready  in  1  BTB accepts the write.
- btb_wr_index  out  IDX_W  entry index.
- btb_wr_pc  out  ADDR_W  tag PC.
- btb_wr_target  out  ADDR_W  target.
- btb_wr_counter  out  2  updated direction counter.

Behaviour:
- Reset: FSM=IDLE; FIFO empty; all counters = 2'b01 (weakly not-taken); every output 0 except res_ready=1.
- Accept condition: res_valid && res_ready. res_ready = (state==IDLE) && !fifo_full. Push when full is never allowed, even with a simultaneous pop.
- Opcode classes:
  - 1100011 (cond branch): checked and queued.
  - 1101111 (JAL): checked only, never queued, counters untouched.
  - Any other opcode: accepted and ignored.
- Mispredict = (res_taken != pred_taken) || (res_taken && pred_taken && res_target != pred_target).
- Correct PC = res_taken ? res_target : res_pc + 4, computed modulo 2^ADDR_W.
- FSM:
  - IDLE: an accepted mispredict → REDIRECT. redirect_pc is registered on the same edge.
  - REDIRECT (exactly 1 cycle): redirect_valid=1, flush=1. Next state is DRAIN.
  - DRAIN: flush=1 until flush_ack=1, then IDLE. flush_ack sampled high in REDIRECT is ignored.
- Latency: redirect_valid rises the cycle after acceptance.
- Resolves are not accepted in REDIRECT/DRAIN (wrong path). The queued update for the mispredicted branch itself is kept.
- Index = res_pc[IDX_W+1:2]. The FIFO stores {index, pc, target, taken}.
- Counter update at FIFO pop (handshake completes):
  - taken: saturating +1, max 11.
  - not-taken: saturating −1, min 00.
  - Table updated on the same edge. btb_wr_counter shows the post-update value, computed combinationally from table[head index].
- btb_wr_valid = !fifo_empty. Head fields stay stable while valid && !ready.
- Same index already in the FIFO twice: each pop reads the table as already updated by earlier pops. This is strict in-order read-modify-write.
- FIFO pointers wrap modulo UPD_DEPTH. Full/empty are tracked by an extra pointer bit.
- Reset mid-operation wins over everything: FIFO flushed, FSM to IDLE, counters re-initialised, flush dropped the next cycle.

Optional Feature:
- Macro: BRANCH_RESOLVER_STATS_EN.
- With the macro defined, adds outputs stat_branches[31:0] and stat_mispredicts[31:0]:
  - stat_branches increments on each accepted cond branch or JAL.
  - stat_mispredicts increments on each accepted mispredict.
  - Both wrap at 2^32 and clear on reset.
- Without it, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package branch_pkg:
  - Opcode constants OP_BRANCH=7'b1100011 and OP_JAL=7'b1101111.
  - Counter encodings CNT_SNT/WNT/WT/ST.
  - struct btb_update_t {index, pc, target, taken}.
  - Resolver FSM state enum.
- One sub-module: branch_update_fifo. It is a generic synchronous FIFO of btb_update_t, parameterised by UPD_DEPTH, with full/empty flags.

Test Plan:
- Correct not-taken: branch res_pc=0x100, pred_taken=0, res_taken=0 → no redirect. One BTB write at index 0 with counter 00.
- Direction mispredict: branch pc=0x200, pred_taken=0, res_taken=1, target=0x240 → next cycle redirect_valid=1 with redirect_pc=0x240. flush stays high until flush_ack, and res_ready=0 throughout.
- Target mispredict: JAL pc=0x300, pred target 0x380, actual 0x3C0 → redirect_pc=0x3C0. No BTB write.
- Backpressure: btb_wr_ready=0 and 5 correct branches → the 5th sees res_ready=0. Raising ready drains 4 writes in order.
- Saturation: 4 taken resolves at pc=0x40 → counters 10, 11, 11, 11 on successive writes.
- Reset during DRAIN with 2 queued → next cycle flush=0, btb_wr_valid=0, res_ready=1.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: types and constants shared by the execute-side branch resolver.
// Widths come from ADDRESS_SIZE / INSTRUCTION_SIZE / BTB_SIZE when defined
// at compile time, otherwise from the defaults below.
// Contents: opcode classes, 2-bit counter encodings, BTB update payload,
// resolver FSM states and the counter saturation helper.

`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 64
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 32
`endif
`ifndef BTB_SIZE
`define BTB_SIZE 16
`endif

package branch_pkg;

    localparam int unsigned ADDR_W      = `ADDRESS_SIZE;
    localparam int unsigned INSTR_W     = `INSTRUCTION_SIZE;
    localparam int unsigned BTB_ENTRIES = `BTB_SIZE;
    localparam int unsigned IDX_W       = $clog2(BTB_ENTRIES);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    typedef struct packed {
        logic [IDX_W-1:0]  index;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] target;
        logic              taken;
    } btb_update_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REDIRECT,
        ST_DRAIN
    } res_state_t;

    // Saturating step of a 2-bit direction counter.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        unique case (cnt)
            CNT_SNT: nxt = taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: nxt = taken ? CNT_WT  : CNT_SNT;
            CNT_WT:  nxt = taken ? CNT_ST  : CNT_WNT;
            default: nxt = taken ? CNT_ST  : CNT_WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_update_fifo.sv
// branch_update_fifo: synchronous FIFO of btb_update_t entries.
// Ports: clk, reset (sync, active-high), push_i/push_data_i (write),
// pop_i (consume head), head_o (current head), full_o, empty_o.
// Pushes while full and pops while empty are dropped.

module branch_update_fifo
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  btb_update_t push_data_i,
    input  logic        pop_i,
    output btb_update_t head_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    btb_update_t      mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra MSB on the pointers distinguishes full from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage and pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
                wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: compares resolved control flow against the prediction,
// issues a one-shot redirect with flush held until flush_ack, owns the 2-bit
// direction counters and drains queued BTB updates over a ready/valid port.
// Ports: res_* (resolve input, res_ready back-pressure), pred_* (prediction
// carried down the pipe), redirect_valid/redirect_pc, flush/flush_ack,
// btb_wr_* (BTB write handshake with post-update counter).
// Optional: define BRANCH_RESOLVER_STATS_EN to add stat_branches and
// stat_mispredicts counters.

module branch_resolver
    import branch_pkg::*;
#(
    parameter int unsigned UPD_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               res_valid,
    output logic               res_ready,
    input  logic [ADDR_W-1:0]  res_pc,
    input  logic [INSTR_W-1:0] res_instruction,
    input  logic               res_taken,
    input  logic [ADDR_W-1:0]  res_target,
    input  logic               pred_taken,
    input  logic [ADDR_W-1:0]  pred_target,
    output logic               redirect_valid,
    output logic [ADDR_W-1:0]  redirect_pc,
    output logic               flush,
    input  logic               flush_ack,
    output logic               btb_wr_valid,
    input  logic               btb_wr_ready,
    output logic [IDX_W-1:0]   btb_wr_index,
    output logic [ADDR_W-1:0]  btb_wr_pc,
    output logic [ADDR_W-1:0]  btb_wr_target,
    output logic [1:0]         btb_wr_counter
`ifdef BRANCH_RESOLVER_STATS_EN
   ,output logic [31:0]        stat_branches
   ,output logic [31:0]        stat_mispredicts
`endif
);

    res_state_t        state_q, state_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic              flush_q, flush_d;
    logic [1:0]        cnt_q [BTB_ENTRIES];

    logic [6:0]        opcode;
    logic              is_branch;
    logic              is_jal;
    logic              accept;
    logic              mispredict;
    logic [ADDR_W-1:0] correct_pc;
    logic              unused_instr;

    btb_update_t       push_data;
    btb_update_t       head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [1:0]        cnt_upd;

    // Decode and compare against the prediction.
    assign opcode       = res_instruction[6:0];
    assign unused_instr = ^res_instruction[INSTR_W-1:7];
    assign is_branch    = (opcode == OP_BRANCH);
    assign is_jal       = (opcode == OP_JAL);
    assign res_ready    = (state_q == ST_IDLE) && !fifo_full;
    assign accept       = res_valid && res_ready;
    assign mispredict   = (res_taken != pred_taken) ||
                          (res_taken && pred_taken && (res_target != pred_target));
    assign correct_pc   = res_taken ? res_target : (res_pc + ADDR_W'(4));

    // Only conditional branches train the BTB/counters; the mispredicted
    // branch's own update is queued even though it triggers a redirect.
    assign fifo_push        = accept && is_branch;
    assign push_data.index  = res_pc[IDX_W+1:2];
    assign push_data.pc     = res_pc;
    assign push_data.target = res_target;
    assign push_data.taken  = res_taken;

    branch_update_fifo #(
        .DEPTH (UPD_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (push_data),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Head drives the BTB write port; counter shown is the post-update value.
    assign btb_wr_valid   = !fifo_empty;
    assign fifo_pop       = btb_wr_valid && btb_wr_ready;
    assign cnt_upd        = cnt_next(cnt_q[head.index], head.taken);
    assign btb_wr_index   = head.index;
    assign btb_wr_pc      = head.pc;
    assign btb_wr_target  = head.target;
    assign btb_wr_counter = cnt_upd;

    // Direction counters, written back when the BTB accepts the update.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '{default: CNT_WNT};
        end else if (fifo_pop) begin
            cnt_q[head.index] <= cnt_upd;
        end
    end

    // Redirect/flush FSM next-state and registered-output decode.
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && (is_branch || is_jal) && mispredict) begin
                    state_d       = ST_REDIRECT;
                    redirect_pc_d = correct_pc;
                end
            end
            ST_REDIRECT: state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (flush_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        redirect_valid_d = (state_d == ST_REDIRECT);
        flush_d          = (state_d != ST_IDLE);
    end

    // FSM state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            redirect_pc_q    <= '0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            redirect_pc_q    <= redirect_pc_d;
            redirect_valid_q <= redirect_valid_d;
            flush_q          <= flush_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispredicts_q;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else if (accept && (is_branch || is_jal)) begin
            stat_branches_q <= stat_branches_q + 32'd1;
            if (mispredict) begin
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed bench with a scoreboard of expected BTB writes.
module tb_branch_resolver;
    import branch_pkg::*;

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] tgt;
        logic [1:0]        cnt;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               res_valid;
    logic               res_ready;
    logic [ADDR_W-1:0]  res_pc;
    logic [INSTR_W-1:0] res_instruction;
    logic               res_taken;
    logic [ADDR_W-1:0]  res_target;
    logic               pred_taken;
    logic [ADDR_W-1:0]  pred_target;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               flush;
    logic               flush_ack;
    logic               btb_wr_valid;
    logic               btb_wr_ready;
    logic [IDX_W-1:0]   btb_wr_index;
    logic [ADDR_W-1:0]  btb_wr_pc;
    logic [ADDR_W-1:0]  btb_wr_target;
    logic [1:0]         btb_wr_counter;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [1:0] model_cnt [BTB_ENTRIES];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    branch_resolver #(.UPD_DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_pc          (res_pc),
        .res_instruction (res_instruction),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .flush           (flush),
        .flush_ack       (flush_ack),
        .btb_wr_valid    (btb_wr_valid),
        .btb_wr_ready    (btb_wr_ready),
        .btb_wr_index    (btb_wr_index),
        .btb_wr_pc       (btb_wr_pc),
        .btb_wr_target   (btb_wr_target),
        .btb_wr_counter  (btb_wr_counter)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? 2'b11 : c + 2'b01;
        else   return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(BTB_ENTRIES); i++) model_cnt[i] = 2'b01;
        sb.delete();
    endtask

    // Drive one resolve for a cycle; the caller ensures res_ready is high.
    task automatic send(input logic [6:0] op, input logic [63:0] pc, input logic tk,
                        input logic [63:0] tgt, input logic ptk, input logic [63:0] ptgt);
        logic [IDX_W-1:0] ix;
        res_valid       = 1'b1;
        res_instruction = INSTR_W'(op);
        res_pc          = pc;
        res_taken       = tk;
        res_target      = tgt;
        pred_taken      = ptk;
        pred_target     = ptgt;
        step();
        res_valid = 1'b0;
        if (op == OP_BRANCH) begin
            ix = pc[IDX_W+1:2];
            model_cnt[ix] = sat(model_cnt[ix], tk);
            sb.push_back('{ix, pc, tgt, model_cnt[ix]});
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 50 && sb.size() != 0; i++) step();
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    // Compare every completed BTB write against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && btb_wr_valid && btb_wr_ready) begin
            if (sb.size() == 0) begin
                chk("btb_unexpected_write", 64'(btb_wr_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("btb_index",   64'(btb_wr_index),   64'(mon_e.idx));
                chk("btb_pc",      btb_wr_pc,           mon_e.pc);
                chk("btb_target",  btb_wr_target,       mon_e.tgt);
                chk("btb_counter", 64'(btb_wr_counter), 64'(mon_e.cnt));
            end
        end
    end

    initial begin
        reset = 1'b1; res_valid = 1'b0; res_pc = '0; res_instruction = '0;
        res_taken = 1'b0; res_target = '0; pred_taken = 1'b0; pred_target = '0;
        flush_ack = 1'b0; btb_wr_ready = 1'b1;
        model_reset();
        step(); step();
        reset = 1'b0;

        // Reset state
        chk("rst_res_ready",   64'(res_ready),      64'd1);
        chk("rst_redir_valid", 64'(redirect_valid), 64'd0);
        chk("rst_redir_pc",    redirect_pc,         64'd0);
        chk("rst_flush",       64'(flush),          64'd0);
        chk("rst_btb_valid",   64'(btb_wr_valid),   64'd0);

        // Correct not-taken branch
        send(OP_BRANCH, 64'h100, 1'b0, 64'h0, 1'b0, 64'h0);
        chk("t1_no_redirect", 64'(redirect_valid), 64'd0);
        chk("t1_no_flush",    64'(flush),          64'd0);
        wait_drain("t1_drain");

        // Direction mispredict; flush_ack during REDIRECT is ignored
        send(OP_BRANCH, 64'h200, 1'b1, 64'h240, 1'b0, 64'h0);
        chk("t2_redir_valid", 64'(redirect_valid), 64'd1);
        chk("t2_redir_pc",    redirect_pc,         64'h240);
        chk("t2_flush",       64'(flush),          64'd1);
        chk("t2_ready_low",   64'(res_ready),      64'd0);
        flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;
        chk("t2_redir_pulse", 64'(redirect_valid), 64'd0);
        chk("t2_ack_ignored", 64'(flush),          64'd1);
        step(); step();
        chk("t2_flush_held",  64'(flush),          64'd1);
        chk("t2_ready_drain", 64'(res_ready),      64'd0);
        flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;
        chk("t2_flush_clear", 64'(flush),          64'd0);
        chk("t2_ready_back",  64'(res_ready),      64'd1);
        wait_drain("t2_drain");

        // JAL target mispredict: redirect only, no BTB write
        send(OP_JAL, 64'h300, 1'b1, 64'h3C0, 1'b1, 64'h380);
        chk("t3_redir_valid", 64'(redirect_valid), 64'd1);
        chk("t3_redir_pc",    redirect_pc,         64'h3C0);
        chk("t3_no_btb",      64'(btb_wr_valid),   64'd0);
        step();
        flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;
        chk("t3_flush_clear", 64'(flush),          64'd0);

        // Unrelated opcode with mismatching prediction is ignored
        send(7'b0110011, 64'h380, 1'b1, 64'h999, 1'b0, 64'h0);
        chk("t7_ignored_redir", 64'(redirect_valid), 64'd0);
        chk("t7_ignored_btb",   64'(btb_wr_valid),   64'd0);

        // Backpressure: four fill the FIFO, a fifth is refused
        btb_wr_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(OP_BRANCH, 64'h500 + 64'(4 * i), 1'b0, 64'h0, 1'b0, 64'h0);
        chk("t4_full_ready",  64'(res_ready),    64'd0);
        chk("t4_btb_valid",   64'(btb_wr_valid), 64'd1);
        res_valid = 1'b1; res_instruction = INSTR_W'(OP_BRANCH); res_pc = 64'h510;
        step();
        res_valid = 1'b0;
        chk("t4_head_stable", btb_wr_pc,         64'h500);
        btb_wr_ready = 1'b1;
        wait_drain("t4_drain");
        chk("t4_no_fifth",    64'(btb_wr_valid), 64'd0);

        // Reset during DRAIN with two updates queued
        btb_wr_ready = 1'b0;
        send(OP_BRANCH, 64'h600, 1'b0, 64'h0, 1'b0, 64'h0);
        send(OP_BRANCH, 64'h604, 1'b1, 64'h700, 1'b0, 64'h0);
        chk("t6_redir_valid", 64'(redirect_valid), 64'd1);
        step();
        chk("t6_flush_drain", 64'(flush),          64'd1);
        chk("t6_queued",      64'(btb_wr_valid),   64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        chk("t6_flush_reset", 64'(flush),          64'd0);
        chk("t6_btb_reset",   64'(btb_wr_valid),   64'd0);
        chk("t6_ready_reset", 64'(res_ready),      64'd1);
        chk("t6_redir_reset", 64'(redirect_valid), 64'd0);
        btb_wr_ready = 1'b1;

        // Saturation: four taken at the same index, all queued before draining
        btb_wr_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(OP_BRANCH, 64'h40, 1'b1, 64'h80, 1'b1, 64'h80);
        chk("t5_no_redirect", 64'(redirect_valid), 64'd0);
        chk("t5_full_ready",  64'(res_ready),      64'd0);
        btb_wr_ready = 1'b1;
        wait_drain("t5_drain");

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
